pellet_map_arbiter: RTL and testbench
=====================================

// Module: pellet_map_arbiter
// PURPOSE
// Owns the single-port 1-bit pellet map RAM and shares it between the pixel renderer (reads) and game logic
// (pellet-eat read-modify-write, level refill sweep). Renderer has absolute priority during active video;
// game accesses run only in blanking. Tracks pellets remaining and flags level clear.
// PARAMETERS
// MAP_CELLS     1200  cells in map (40x30 tiles of 16x16 px); valid addresses 0..MAP_CELLS-1
// PELLET_TOTAL  240   value loaded into pellets_left when a refill sweep completes
// PORTS
// clk           in   1   system clock
// rst           in   1   synchronous active-high reset
// render_active in   1   1 = visible region, renderer owns RAM this cycle
// render_addr   in   12  renderer map address, (pixel_y>>4)*40+(pixel_x>>4)
// render_pellet out  1   pellet bit for render_addr of previous cycle
// eat_valid     in   1   game requests pellet clear at eat_addr
// eat_addr      in   12  tile address to eat
// eat_ready     out  1   request accepted when eat_valid&&eat_ready
// eat_done      out  1   1-cycle pulse, eat transaction finished
// eat_hit       out  1   valid with eat_done: 1 = pellet was present and is now cleared
// refill_req    in   1   1-cycle pulse: refill every cell with a pellet
// busy          out  1   refill pending or in progress
// pellets_left  out  11  pellets remaining
// level_clear   out  1   pellets_left==0 && !busy
// BEHAVIOUR
// - Reset: state=REFILL, sweep addr=0, pellets_left=0, render_pellet=0, eat_ready=0, eat_done=0, eat_hit=0,
//   busy=1; refill_pend=0. Reset mid-transaction abandons it; no eat_done issued.
// - RAM port: render_active=1 -> addr=render_addr, read. render_active=0 -> port owned by FSM (idle reads nothing).
// - render_pellet registered: = RAM data if render_active was 1 last cycle and busy was 0, else 0. Latency 1.
// - FSM states: REFILL, IDLE, RD, WR.
//   REFILL: each cycle with render_active=0 write 1 at sweep addr, addr++; cycles with render_active=1 stall.
//     After writing MAP_CELLS-1: pellets_left<=PELLET_TOTAL, busy<=0, ->IDLE. Sweep addr wraps to 0 on exit.
//   IDLE: eat_ready=1 iff !refill_pend. If refill_pend: clear it, ->REFILL (busy stays 1).
//     Else accept eat: latch eat_addr, ->RD. Same-cycle refill_req and eat_valid: refill wins, eat not accepted.
//   RD: waits for render_active=0; then reads latched addr, ->WR. Addr>=MAP_CELLS: no read, ->WR with data=0.
//   WR: read data captured on entry; waits for render_active=0 (render owns port); then if data=1 write 0 and
//     pellets_left-- (saturating at 0); eat_done=1, eat_hit=data for that one cycle; ->IDLE.
// - refill_req in any state sets refill_pend (busy=1 next cycle); a running eat completes first. refill_req
//   during REFILL restarts nothing (pend served after current sweep -> second sweep).
// - eat_ready is 0 in REFILL, RD, WR. Min eat turnaround in blanking: accept->eat_done = 2 cycles.
// - level_clear combinational from registered pellets_left and busy; 0 during refill.
// CONFIGURATION
// PELLET_SCORE_EN defined: adds output score [15:0]; reset to 0 (only by rst, not refill); +10 per eat_hit,
//   saturating at 16'hFFFF, updated same cycle as eat_done. Undefined: no score port, no counter logic.
// TESTING
// T1 reset, render_active=0 throughout -> busy=1 for 1200 cycles, then busy=0, pellets_left=240, eat_ready=1.
// T2 after refill, render_active=1, render_addr=41 -> render_pellet=1 next cycle; render_active=0 -> render_pellet=0.
// T3 eat addr 41 in blanking -> eat_done 2 cycles after accept, eat_hit=1, pellets_left=239; eat 41 again ->
//    eat_hit=0, pellets_left=239; render read of 41 -> 0.
// T4 eat accepted then render_active=1 for 50 cycles -> RD stalls, no eat_done until blanking; render_pellet
//    values correct throughout; eat_addr=1300 -> eat_hit=0, count unchanged.
// T5 refill_req and eat_valid same IDLE cycle -> eat_ready=0, refill runs, pellets_left=240; refill_req during
//    RD -> eat completes with eat_done, then refill.
// T6 PELLET_TOTAL=2: two hits -> pellets_left=0, level_clear=1; third distinct hit keeps 0; with PELLET_SCORE_EN
//    score=20 after two hits, unchanged by refill, 0 after rst.

Source files
------------

// File: rtl/pellet_map_arbiter.sv
// Pellet map RAM owner: renderer reads in active video, game eats and refill sweeps run in blanking.
// Optional PELLET_SCORE_EN adds a saturating score output (+10 per pellet eaten).
module pellet_map_arbiter #(
    parameter int MAP_CELLS    = 1200,
    parameter int PELLET_TOTAL = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        render_active,
    input  logic [11:0] render_addr,
    output logic        render_pellet,
    input  logic        eat_valid,
    input  logic [11:0] eat_addr,
    output logic        eat_ready,
    output logic        eat_done,
    output logic        eat_hit,
    input  logic        refill_req,
    output logic        busy,
    output logic [10:0] pellets_left,
`ifdef PELLET_SCORE_EN
    output logic [15:0] score,
`endif
    output logic        level_clear
);

    localparam int          AW        = $clog2(MAP_CELLS);
    localparam logic [12:0] CELLS_L   = 13'(MAP_CELLS);
    localparam logic [11:0] LAST_ADDR = 12'(MAP_CELLS - 1);
    localparam logic [10:0] TOTAL_L   = 11'(PELLET_TOTAL);

    typedef enum logic [1:0] {REFILL, IDLE, RD, WR} state_t;

    state_t      state_q, state_d;
    logic [11:0] sweep_q, sweep_d;
    logic [10:0] pellets_q, pellets_d;
    logic        busy_q, busy_d;
    logic        pend_q, pend_d;
    logic [11:0] eat_addr_q, eat_addr_d;
    logic        eat_data_q;
    logic        render_pellet_q;
    logic        ram_we, ram_wdata, eat_rd_en;
    logic [11:0] ram_waddr;
    logic        mem_q [0:MAP_CELLS-1];

    logic render_in_range, eat_in_range;
    assign render_in_range = {1'b0, render_addr} < CELLS_L;
    assign eat_in_range    = {1'b0, eat_addr_q} < CELLS_L;

`ifdef PELLET_SCORE_EN
    logic [15:0] score_q, score_d;
`endif

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        pellets_d  = pellets_q;
        pend_d     = pend_q | refill_req;
        eat_addr_d = eat_addr_q;
        eat_ready  = 1'b0;
        eat_done   = 1'b0;
        eat_hit    = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = 1'b0;
        ram_waddr  = sweep_q;
        eat_rd_en  = 1'b0;
`ifdef PELLET_SCORE_EN
        score_d    = score_q;
`endif
        case (state_q)
            REFILL: begin
                if (!render_active) begin
                    ram_we    = 1'b1;
                    ram_wdata = 1'b1;
                    if (sweep_q == LAST_ADDR) begin
                        sweep_d   = '0;
                        pellets_d = TOTAL_L;
                        state_d   = IDLE;
                    end else begin
                        sweep_d = sweep_q + 12'd1;
                    end
                end
            end
            IDLE: begin
                // A same-cycle refill request blocks the eat so the refill wins.
                eat_ready = !pend_q && !refill_req;
                if (pend_q) begin
                    pend_d  = refill_req;
                    state_d = REFILL;
                end else if (eat_valid && eat_ready) begin
                    eat_addr_d = eat_addr;
                    state_d    = RD;
                end
            end
            RD: begin
                if (!render_active) begin
                    eat_rd_en = 1'b1;
                    state_d   = WR;
                end
            end
            WR: begin
                if (!render_active) begin
                    eat_done = 1'b1;
                    eat_hit  = eat_data_q;
                    if (eat_data_q) begin
                        ram_we    = 1'b1;
                        ram_waddr = eat_addr_q;
                        if (pellets_q != 11'd0) pellets_d = pellets_q - 11'd1;
`ifdef PELLET_SCORE_EN
                        score_d = (score_q > 16'hFFF5) ? 16'hFFFF : score_q + 16'd10;
`endif
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = REFILL;
        endcase
        busy_d = pend_d || (state_d == REFILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= REFILL;
            sweep_q         <= '0;
            pellets_q       <= '0;
            busy_q          <= 1'b1;
            pend_q          <= 1'b0;
            eat_addr_q      <= '0;
            eat_data_q      <= 1'b0;
            render_pellet_q <= 1'b0;
`ifdef PELLET_SCORE_EN
            score_q         <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            pellets_q  <= pellets_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            eat_addr_q <= eat_addr_d;
            if (eat_rd_en)
                eat_data_q <= eat_in_range ? mem_q[eat_addr_q[AW-1:0]] : 1'b0;
            render_pellet_q <= (render_active && !busy_q && render_in_range)
                               ? mem_q[render_addr[AW-1:0]] : 1'b0;
`ifdef PELLET_SCORE_EN
            score_q    <= score_d;
`endif
        end
    end

    // Map storage itself has no reset; the refill sweep initialises it.
    always_ff @(posedge clk) begin
        if (ram_we && !rst)
            mem_q[ram_waddr[AW-1:0]] <= ram_wdata;
    end

    assign render_pellet = render_pellet_q;
    assign busy          = busy_q;
    assign pellets_left  = pellets_q;
    assign level_clear   = (pellets_q == 11'd0) && !busy_q;
`ifdef PELLET_SCORE_EN
    assign score         = score_q;
`endif

endmodule

// File: tb/tb_pellet_map_arbiter.sv
// Directed bench for pellet_map_arbiter: refill, render reads, eats, stalls, refill races, level clear.
module tb_pellet_map_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        render_active;
    logic [11:0] render_addr;
    logic        render_pellet;
    logic        eat_valid;
    logic [11:0] eat_addr;
    logic        eat_ready;
    logic        eat_done;
    logic        eat_hit;
    logic        refill_req;
    logic        busy;
    logic [10:0] pellets_left;
    logic        level_clear;
`ifdef PELLET_SCORE_EN
    logic [15:0] score;
`endif

    int totalChecks = 0;
    int badChecks   = 0;
    int expHits     = 0;

    always #5 clk = ~clk;

    pellet_map_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .render_active (render_active),
        .render_addr   (render_addr),
        .render_pellet (render_pellet),
        .eat_valid     (eat_valid),
        .eat_addr      (eat_addr),
        .eat_ready     (eat_ready),
        .eat_done      (eat_done),
        .eat_hit       (eat_hit),
        .refill_req    (refill_req),
        .busy          (busy),
        .pellets_left  (pellets_left),
`ifdef PELLET_SCORE_EN
        .score         (score),
`endif
        .level_clear   (level_clear)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d want %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic [11:0] raddr, input logic ev,
                                 input logic [11:0] eaddr, input logic rr);
        render_active = ra;
        render_addr   = raddr;
        eat_valid     = ev;
        eat_addr      = eaddr;
        refill_req    = rr;
    endtask

    task automatic waitRefill(output int cycles);
        cycles = 0;
        while (busy && cycles < 3000) begin
            step();
            cycles++;
        end
        if (busy) checkOutput("refillTimeout", 32'(busy), 32'd0);
    endtask

    task automatic doEat(input logic [11:0] addr, output logic hit, output int lat);
        applyStimulus(1'b0, 12'd0, 1'b1, addr, 1'b0);
        #1;
        checkOutput("eatReady", 32'(eat_ready), 32'd1);
        step();
        eat_valid = 1'b0;
        lat = 1;
        while (!eat_done && lat < 100) begin
            step();
            lat++;
        end
        checkOutput("eatDoneSeen", 32'(eat_done), 32'd1);
        hit = eat_hit;
        step();
        checkOutput("eatDonePulse", 32'(eat_done), 32'd0);
    endtask

    initial begin
        logic hit;
        int   lat;
        int   n;
        logic expR;

        rst = 1'b1;
        applyStimulus(1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
        step();
        step();
        checkOutput("rstBusy", 32'(busy), 32'd1);
        checkOutput("rstPellets", 32'(pellets_left), 32'd0);
        checkOutput("rstEatReady", 32'(eat_ready), 32'd0);
        checkOutput("rstEatDone", 32'(eat_done), 32'd0);
        checkOutput("rstEatHit", 32'(eat_hit), 32'd0);
        checkOutput("rstRender", 32'(render_pellet), 32'd0);
        checkOutput("rstLevelClear", 32'(level_clear), 32'd0);
`ifdef PELLET_SCORE_EN
        checkOutput("rstScore", 32'(score), 32'd0);
`endif

        // Initial sweep: one cell per blanking cycle
        rst = 1'b0;
        waitRefill(n);
        checkOutput("refillCycles", 32'(n), 32'd1200);
        checkOutput("refillPellets", 32'(pellets_left), 32'd240);
        #1;
        checkOutput("idleEatReady", 32'(eat_ready), 32'd1);
        checkOutput("idleLevelClear", 32'(level_clear), 32'd0);

        // Render read, then blanking forces zero
        applyStimulus(1'b1, 12'd41, 1'b0, 12'd0, 1'b0);
        step();
        checkOutput("renderHit41", 32'(render_pellet), 32'd1);
        applyStimulus(1'b0, 12'd41, 1'b0, 12'd0, 1'b0);
        step();
        checkOutput("renderBlank", 32'(render_pellet), 32'd0);

        // Eat 41 twice
        doEat(12'd41, hit, lat);
        checkOutput("eat41Latency", 32'(lat), 32'd2);
        checkOutput("eat41Hit", 32'(hit), 32'd1);
        expHits++;
        checkOutput("eat41Pellets", 32'(pellets_left), 32'd239);
        doEat(12'd41, hit, lat);
        checkOutput("eat41AgainHit", 32'(hit), 32'd0);
        checkOutput("eat41AgainPellets", 32'(pellets_left), 32'd239);
        applyStimulus(1'b1, 12'd41, 1'b0, 12'd0, 1'b0);
        step();
        checkOutput("render41Eaten", 32'(render_pellet), 32'd0);

        // Eat accepted, then active video stalls it for 50 cycles
        applyStimulus(1'b0, 12'd0, 1'b1, 12'd100, 1'b0);
        #1;
        checkOutput("stallEatReady", 32'(eat_ready), 32'd1);
        step();
        eat_valid     = 1'b0;
        render_active = 1'b1;
        for (int i = 0; i < 50; i++) begin
            case (i % 3)
                0:       begin render_addr = 12'd41;   expR = 1'b0; end
                1:       begin render_addr = 12'd42;   expR = 1'b1; end
                default: begin render_addr = 12'd1250; expR = 1'b0; end
            endcase
            step();
            checkOutput("stallNoDone", 32'(eat_done), 32'd0);
            checkOutput("stallRender", 32'(render_pellet), 32'(expR));
        end
        checkOutput("stallEatReadyLow", 32'(eat_ready), 32'd0);
        render_active = 1'b0;
        lat = 0;
        while (!eat_done && lat < 100) begin
            step();
            lat++;
        end
        checkOutput("stallResumeLatency", 32'(lat), 32'd1);
        checkOutput("stallHit", 32'(eat_hit), 32'd1);
        expHits++;
        checkOutput("stallRenderBlank", 32'(render_pellet), 32'd0);
        step();
        checkOutput("stallPellets", 32'(pellets_left), 32'd238);
        doEat(12'd1300, hit, lat);
        checkOutput("outOfRangeHit", 32'(hit), 32'd0);
        checkOutput("outOfRangePellets", 32'(pellets_left), 32'd238);

        // Refill and eat in the same IDLE cycle: refill wins
        applyStimulus(1'b0, 12'd0, 1'b1, 12'd5, 1'b1);
        #1;
        checkOutput("raceEatReady", 32'(eat_ready), 32'd0);
        step();
        applyStimulus(1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
        checkOutput("raceBusy", 32'(busy), 32'd1);
        checkOutput("raceEatReadyPend", 32'(eat_ready), 32'd0);
        waitRefill(n);
        checkOutput("raceRefillPellets", 32'(pellets_left), 32'd240);
        applyStimulus(1'b1, 12'd41, 1'b0, 12'd0, 1'b0);
        step();
        checkOutput("render41Refilled", 32'(render_pellet), 32'd1);

        // Refill requested while an eat is in RD
        applyStimulus(1'b0, 12'd0, 1'b1, 12'd7, 1'b0);
        step();
        applyStimulus(1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
        step();
        refill_req = 1'b0;
        checkOutput("rdRefillDone", 32'(eat_done), 32'd1);
        checkOutput("rdRefillHit", 32'(eat_hit), 32'd1);
        checkOutput("rdRefillBusy", 32'(busy), 32'd1);
        expHits++;
        step();
        checkOutput("rdRefillPellets", 32'(pellets_left), 32'd239);
        checkOutput("rdRefillEatReady", 32'(eat_ready), 32'd0);
        waitRefill(n);
        checkOutput("rdRefillReload", 32'(pellets_left), 32'd240);

        // Eat every counted pellet, then one more
        for (int a = 0; a < 240; a++) begin
            doEat(12'(a), hit, lat);
            checkOutput("sweepEatHit", 32'(hit), 32'd1);
            expHits++;
        end
        checkOutput("clearPellets", 32'(pellets_left), 32'd0);
        checkOutput("clearLevel", 32'(level_clear), 32'd1);
        doEat(12'd500, hit, lat);
        checkOutput("extraHit", 32'(hit), 32'd1);
        expHits++;
        checkOutput("extraPelletsSat", 32'(pellets_left), 32'd0);
        checkOutput("extraLevelClear", 32'(level_clear), 32'd1);
`ifdef PELLET_SCORE_EN
        checkOutput("scoreAfterEats", 32'(score), 32'(expHits * 10));
`endif

        applyStimulus(1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
        step();
        refill_req = 1'b0;
        checkOutput("refillLevelClearLow", 32'(level_clear), 32'd0);
        waitRefill(n);
        checkOutput("finalRefillPellets", 32'(pellets_left), 32'd240);
`ifdef PELLET_SCORE_EN
        checkOutput("scoreKeptByRefill", 32'(score), 32'(expHits * 10));
`endif

        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("reRstPellets", 32'(pellets_left), 32'd0);
        checkOutput("reRstBusy", 32'(busy), 32'd1);
`ifdef PELLET_SCORE_EN
        checkOutput("reRstScore", 32'(score), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
